telemetry_framer: RTL and testbench
===================================

// Module: telemetry_framer
// PURPOSE
//  Upstream feeder for the UART transmitter. Latches a block of telemetry words, then emits one frame byte by byte:
//  SYNC, LEN, payload, CHECKSUM. Each byte goes out on txByte/txSend.
//  The UART TX input has no ready/backpressure, so the framer paces bytes at a fixed gap of at least one UART character time.
// PARAMETERS
//  NUM_WORDS      4     words per frame
//  WORD_BITS      16    bits per word; multiple of 8
//  SYNC_BYTE      8'hA5 first byte of every frame
//  BYTE_GAP_CLKS  1530  clocks between successive byte presentations; >=4 (1530 >= 11*139)
// PORTS
//  clock      in   1                     system clock, rising edge
//  reset_n    in   1                     asynchronous active-low reset
//  frameData  in   NUM_WORDS*WORD_BITS   word 0 in MSBs; sampled only on accepted frameStart
//  frameStart in   1                     request frame; level-sampled each clock
//  busy       out  1                     frame in progress; frameStart ignored while high
//  txByte     out  8                     byte to UART TX txIn
//  txSend     out  1                     to UART TX send; rising edge loads txByte
//  frameDone  out  1                     1-cycle pulse after last byte's gap expires
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, txByte=8'h00, txSend=0, frameDone=0, counters=0; frame in flight is abandoned.
//  PLEN = NUM_WORDS*WORD_BITS/8; frame = PLEN+3 bytes.
//  States:
//   IDLE: frameStart=1 at cycle t -> latch frameData, clear checksum, go SEND.
//   SEND: byte 0 presented at t+1.
//   GAP:  counter runs.
//   DONE.
//  Byte k presented at cycle Tk: txByte takes the new value at Tk and holds it until T(k+1).
//   txSend=1 in cycles Tk+1 and Tk+2 only, so data is stable 1 clock before the send rising edge.
//   T(k+1) = Tk + BYTE_GAP_CLKS.
//  Byte order: SYNC_BYTE, LEN=PLEN[7:0], payload MSB-first (word 0 high byte first), CHECKSUM.
//  CHECKSUM = (LEN + all payload bytes) mod 256. SYNC is excluded. 8-bit accumulator, wraps silently.
//  After the CHECKSUM byte: DONE at Tlast + BYTE_GAP_CLKS. frameDone=1 for that single cycle, busy still 1.
//   The next cycle is IDLE with busy=0.
//  busy=1 from t+1 through the DONE cycle inclusive.
//  frameStart during busy (including DONE) is ignored, not queued. frameData changes during a frame have no effect.
//  Back-to-back: frameStart held high -> new frame accepted in the first IDLE cycle after DONE.
//  txByte keeps the CHECKSUM value while idle until the next frame.
//  Widths:
//   byte index = $clog2(PLEN+3) bits.
//   gap counter = $clog2(BYTE_GAP_CLKS) bits, counts 0..BYTE_GAP_CLKS-1 and never overflows.
//   PLEN must be <=255; LEN is truncated to 8 bits.
// TESTING
//  NUM_WORDS=2, WORD_BITS=16, frameData=32'h1234ABCD, one-cycle frameStart
//   -> bytes A5,04,12,34,AB,CD,C2 on successive txSend rising edges; then one frameDone.
//  Pacing, default params: measure txSend rising edges -> exactly 1530 clocks apart.
//   txByte stable >=1 clock before each rise; txSend high exactly 2 cycles.
//  Checksum wrap: NUM_WORDS=2, frameData=32'hFFFFFFFF -> CHECKSUM=00 (04+4*FF=0x400).
//  frameStart pulsed mid-frame with different frameData
//   -> current frame unchanged, no second frame, busy falls 1 cycle after frameDone.
//  reset_n low during payload byte 3 -> txSend=0, busy=0 immediately (async).
//   After release with no frameStart -> no further bytes.
//  frameStart held high for 3 frames -> consecutive frames separated by exactly 2 cycles (DONE, IDLE) before the next SYNC is presented.

Source files
------------

// File: rtl/telemetry_framer.sv
// Frames a latched block of telemetry words as SYNC, LEN, payload, CHECKSUM and
// paces one byte per BYTE_GAP_CLKS clocks into a UART transmitter with no backpressure.
module telemetry_framer #(
  parameter int         NUM_WORDS     = 4,
  parameter int         WORD_BITS     = 16,
  parameter logic [7:0] SYNC_BYTE     = 8'hA5,
  parameter int         BYTE_GAP_CLKS = 1530
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_WORDS*WORD_BITS-1:0] frameData,
  input  logic                           frameStart,
  output logic                           busy,
  output logic [7:0]                     txByte,
  output logic                           txSend,
  output logic                           frameDone
);

  localparam int DATA_W = NUM_WORDS * WORD_BITS;
  localparam int PLEN   = DATA_W / 8;
  localparam int NBYTES = PLEN + 3;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam int CNT_W  = $clog2(BYTE_GAP_CLKS);

  localparam logic [7:0]       LEN_BYTE = 8'(PLEN);
  localparam logic [IDX_W-1:0] IDX_LEN  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PLEN + 2);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTE_GAP_CLKS - 1);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_DONE} state_t;

  state_t             state_q, state_d;
  logic               busy_q, busy_d;
  logic [7:0]         tx_byte_q, tx_byte_d;
  logic               tx_send_q, tx_send_d;
  logic               frame_done_q, frame_done_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic [7:0]         csum_q, csum_d;
  logic [IDX_W-1:0]   next_idx;
  logic [7:0]         pay_byte;

  assign next_idx = idx_q + IDX_W'(1);
  assign pay_byte = shift_q[DATA_W-1 -: 8];

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    tx_byte_d    = tx_byte_q;
    frame_done_d = 1'b0;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    shift_d      = shift_q;
    csum_d       = csum_q;
    // Send is high for the two cycles after a byte is presented, so txByte
    // has a full clock of setup before the UART sees the rising edge.
    tx_send_d    = (state_q == S_SEND) || ((state_q == S_GAP) && (cnt_q == CNT_ONE));
    case (state_q)
      S_IDLE: begin
        if (frameStart) begin
          shift_d   = frameData;
          csum_d    = '0;
          idx_d     = '0;
          cnt_d     = '0;
          tx_byte_d = SYNC_BYTE;
          busy_d    = 1'b1;
          state_d   = S_SEND;
        end
      end
      S_SEND: begin
        cnt_d   = CNT_ONE;
        state_d = S_GAP;
      end
      S_GAP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d      = S_DONE;
            frame_done_d = 1'b1;
          end else begin
            idx_d   = next_idx;
            state_d = S_SEND;
            if (next_idx == IDX_LEN) begin
              tx_byte_d = LEN_BYTE;
              csum_d    = csum_q + LEN_BYTE;
            end else if (next_idx == IDX_LAST) begin
              tx_byte_d = csum_q;
            end else begin
              tx_byte_d = pay_byte;
              csum_d    = csum_q + pay_byte;
              shift_d   = shift_q << 8;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_DONE: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      tx_byte_q    <= 8'h00;
      tx_send_q    <= 1'b0;
      frame_done_q <= 1'b0;
      idx_q        <= '0;
      cnt_q        <= '0;
      shift_q      <= '0;
      csum_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      tx_byte_q    <= tx_byte_d;
      tx_send_q    <= tx_send_d;
      frame_done_q <= frame_done_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      shift_q      <= shift_d;
      csum_q       <= csum_d;
    end
  end

  assign busy      = busy_q;
  assign txByte    = tx_byte_q;
  assign txSend    = tx_send_q;
  assign frameDone = frame_done_q;

endmodule

// File: tb/tb_telemetry_framer.sv
// Scoreboard bench for telemetry_framer: frames are predicted from frameData and
// compared byte by byte on each txSend rising edge, with pacing and done checks.
module tb_telemetry_framer;
  localparam int NW   = 2;
  localparam int WB   = 16;
  localparam int DW   = NW * WB;
  localparam int PLEN = DW / 8;
  localparam int GAP  = 1530;
  localparam int FRAME_BUDGET = (PLEN + 4) * GAP + 100;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic [DW-1:0] frameData = '0;
  logic          frameStart = 1'b0;
  logic          busy;
  logic [7:0]    txByte;
  logic          txSend;
  logic          frameDone;

  telemetry_framer #(
    .NUM_WORDS(NW), .WORD_BITS(WB), .SYNC_BYTE(8'hA5), .BYTE_GAP_CLKS(GAP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .frameData(frameData), .frameStart(frameStart),
    .busy(busy), .txByte(txByte), .txSend(txSend), .frameDone(frameDone)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] b;
    bit         first;
    bit         last;
    bit         b2b;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0, failures = 0;
  int cyc = 0, rise_cnt = 0, done_cnt = 0, pending_done = 0;
  int last_rise = -1, done_cyc = -1, chg_cyc = 0, send_len = 0;
  logic send_prev = 1'b0, prev_done = 1'b0;
  logic [7:0] byte_prev = 8'h00;

  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Reference frame: SYNC, LEN, payload bytes MSB-first, (LEN + payload) mod 256.
  function automatic void push_frame(input logic [DW-1:0] d, input bit b2b);
    int sum;
    logic [7:0] pb;
    sum = PLEN;
    exp_q.push_back('{b: 8'hA5, first: 1'b1, last: 1'b0, b2b: b2b});
    exp_q.push_back('{b: 8'(PLEN), first: 1'b0, last: 1'b0, b2b: 1'b0});
    for (int j = 0; j < PLEN; j++) begin
      pb = d[DW-1-8*j -: 8];
      sum += int'(pb);
      exp_q.push_back('{b: pb, first: 1'b0, last: 1'b0, b2b: 1'b0});
    end
    exp_q.push_back('{b: 8'(sum % 256), first: 1'b0, last: 1'b1, b2b: 1'b0});
  endfunction

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clock) begin
    exp_t e;
    if (!reset_n) begin
      send_prev = 1'b0;
      send_len  = 0;
      prev_done = 1'b0;
      byte_prev = txByte;
    end else begin
      if (txByte !== byte_prev) chg_cyc = cyc;
      byte_prev = txByte;
      if (txSend && !send_prev) begin
        rise_cnt++;
        check("byte_setup", 32'(chg_cyc < cyc), 32'd1);
        if (exp_q.size() == 0) fail("unexpected_byte");
        else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(txByte), 32'(e.b));
          if (!e.first) check("byte_pacing", 32'(cyc - last_rise), 32'(GAP));
          if (e.first && e.b2b) check("b2b_gap", 32'(cyc - done_cyc), 32'd3);
          if (e.last) pending_done++;
        end
        last_rise = cyc;
      end
      if (txSend) send_len++;
      if (!txSend && send_prev) begin
        check("send_width", 32'(send_len), 32'd2);
        send_len = 0;
      end
      send_prev = txSend;
      if (prev_done) begin
        check("done_width", 32'(frameDone), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
      end
      prev_done = frameDone;
      if (frameDone) begin
        done_cnt++;
        done_cyc = cyc;
        if (pending_done == 0) fail("done_without_frame");
        else pending_done--;
        check("done_timing", 32'(cyc - last_rise), 32'(GAP - 1));
        check("busy_at_done", 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_busy(input logic v);
    int n = 0;
    while (busy !== v && n < FRAME_BUDGET) begin
      @(posedge clock); #1;
      n++;
    end
    if (busy !== v) fail("busy_timeout");
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (done_cnt < target && n < 3 * FRAME_BUDGET) begin
      @(posedge clock); #1;
      n++;
    end
    if (done_cnt < target) fail("done_timeout");
  endtask

  task automatic wait_rises(input int target);
    int n = 0;
    while (rise_cnt < target && n < FRAME_BUDGET) begin
      @(posedge clock);
      n++;
    end
    if (rise_cnt < target) fail("rise_timeout");
  endtask

  task automatic send_frame(input logic [DW-1:0] d);
    wait_busy(1'b0);
    frameData  = d;
    frameStart = 1'b1;
    push_frame(d, 1'b0);
    @(posedge clock); #1;
    frameStart = 1'b0;
    frameData  = DW'($urandom);
  endtask

  initial begin
    logic [DW-1:0] d;
    int r, dn;
    repeat (3) @(posedge clock);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_txbyte", 32'(txByte), 32'h00);
    check("rst_txsend", 32'(txSend), 32'd0);
    check("rst_done", 32'(frameDone), 32'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Known frame and checksum wrap to zero.
    send_frame(32'h1234ABCD);
    wait_done(1);
    send_frame(32'hFFFFFFFF);
    wait_done(2);
    check("idle_holds_csum", 32'(txByte), 32'h00);

    // A start request mid-frame with different data must be dropped.
    d = DW'($urandom);
    send_frame(d);
    wait_rises(rise_cnt + 3);
    @(posedge clock); #1;
    frameData  = ~d;
    frameStart = 1'b1;
    @(posedge clock); #1;
    frameStart = 1'b0;
    wait_done(3);
    r = rise_cnt;
    repeat (100) @(posedge clock);
    #1;
    check("no_queued_frame", 32'(rise_cnt), 32'(r));
    check("busy_idle", 32'(busy), 32'd0);

    // Async reset in the middle of the payload abandons the frame.
    send_frame(DW'($urandom));
    wait_rises(rise_cnt + 5);
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_txsend", 32'(txSend), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    exp_q.delete();
    pending_done = 0;
    @(posedge clock); #1;
    check("rst_mid_txbyte", 32'(txByte), 32'h00);
    reset_n = 1'b1;
    r  = rise_cnt;
    dn = done_cnt;
    repeat (GAP + 10) @(posedge clock);
    #1;
    check("no_bytes_after_rst", 32'(rise_cnt), 32'(r));
    check("no_done_after_rst", 32'(done_cnt), 32'(dn));

    // frameStart held high across three frames.
    dn = done_cnt;
    wait_busy(1'b0);
    d = DW'($urandom);
    frameData  = d;
    frameStart = 1'b1;
    push_frame(d, 1'b0);
    for (int f = 0; f < 2; f++) begin
      wait_busy(1'b1);
      d = DW'($urandom);
      frameData = d;
      push_frame(d, 1'b1);
      wait_busy(1'b0);
    end
    wait_busy(1'b1);
    frameStart = 1'b0;
    wait_done(dn + 3);
    repeat (20) @(posedge clock);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("no_pending_done", 32'(pending_done), 32'd0);
    check("final_idle", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
